// File: rtl/matrix_uart_input_if.sv
// rtl/matrix_uart_input_if.sv - session control and element write bus of matrix_uart_input
interface matrix_uart_input_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  input_start;
  logic [2:0]            input_idx;
  logic                  matrix_wr_en;
  logic [2:0]            matrix_idx;
  logic [2:0]            store_row;
  logic [2:0]            store_col;
  logic [5:0]            wr_addr_in;
  logic [DATA_WIDTH-1:0] matrix_wr_data;
  logic                  input_busy;
  logic                  input_done;
  logic                  input_error;

  modport master (
    input  input_start, input_idx,
    output matrix_wr_en, matrix_idx, store_row, store_col, wr_addr_in,
           matrix_wr_data, input_busy, input_done, input_error
  );

  modport slave (
    output input_start, input_idx,
    input  matrix_wr_en, matrix_idx, store_row, store_col, wr_addr_in,
           matrix_wr_data, input_busy, input_done, input_error
  );
endinterface

// File: rtl/matrix_uart_input.sv
// rtl/matrix_uart_input.sv - 8N1 UART receiver feeding an ASCII decimal matrix parser
module matrix_uart_input #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_SIZE   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  matrix_uart_input_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_ROW  = 2'd1;
  localparam logic [1:0] GET_COL  = 2'd2;
  localparam logic [1:0] GET_ELEM = 2'd3;

  logic        rx_s1_q, rx_s2_q;
  logic [2:0]  rx_state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        byte_valid_q, framing_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_state_q    <= RX_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_s1_q       <= uart_rx;
      rx_s2_q       <= rx_s1_q;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rx_s2_q) begin
          rx_state_q <= RX_START;
          clk_cnt_q  <= '0;
        end
        RX_START: if (clk_cnt_q == 16'(HALF_BIT - 1)) begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          rx_state_q <= rx_s2_q ? RX_WAIT : RX_DATA;
        end else clk_cnt_q <= clk_cnt_q + 16'd1;
        RX_DATA: if (clk_cnt_q == 16'(CLKS_PER_BIT - 1)) begin
          clk_cnt_q <= '0;
          shift_q   <= {rx_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
          else bit_cnt_q <= bit_cnt_q + 3'd1;
        end else clk_cnt_q <= clk_cnt_q + 16'd1;
        RX_STOP: if (clk_cnt_q == 16'(CLKS_PER_BIT - 1)) begin
          byte_valid_q  <= rx_s2_q;
          framing_err_q <= !rx_s2_q;
          rx_state_q    <= RX_WAIT;
        end else clk_cnt_q <= clk_cnt_q + 16'd1;
        RX_WAIT: if (rx_s2_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  logic [1:0]  state_q;
  logic [7:0]  acc_q, tok_val_q;
  logic        ovf_q, pend_q, tok_ovf_q, ev_tok_q, ev_bad_q, done_pend_q;
  logic [5:0]  cnt_q, total_q, wr_addr_q;
  logic [2:0]  matrix_idx_q, store_row_q, store_col_q;
  logic [7:0]  wr_data_q;
  logic        wr_en_q, done_q, error_q;
  logic [11:0] acc_d;
  logic        is_digit, is_sep, tok_in_range;

  assign is_digit     = (shift_q >= 8'h30) && (shift_q <= 8'h39);
  assign is_sep       = (shift_q == 8'h20) || (shift_q == 8'h0D) || (shift_q == 8'h0A);
  assign acc_d        = {4'd0, acc_q} * 12'd10 + {8'd0, shift_q[3:0]};
  assign tok_in_range = (tok_val_q >= 8'd1) && (tok_val_q <= 8'(MAX_SIZE));

  // Stage 1 turns received bytes into token/abort events; stage 2 acts on them
  // one cycle later, which places the element write two cycles after byte_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      tok_val_q    <= '0;
      tok_ovf_q    <= 1'b0;
      ev_tok_q     <= 1'b0;
      ev_bad_q     <= 1'b0;
      done_pend_q  <= 1'b0;
      cnt_q        <= '0;
      total_q      <= '0;
      matrix_idx_q <= '0;
      store_row_q  <= '0;
      store_col_q  <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ev_tok_q <= 1'b0;
      ev_bad_q <= 1'b0;
      if (state_q != IDLE) begin
        if (framing_err_q) ev_bad_q <= 1'b1;
        else if (byte_valid_q) begin
          if (is_digit) begin
            acc_q  <= acc_d[7:0];
            ovf_q  <= ovf_q | (acc_d > 12'd255);
            pend_q <= 1'b1;
          end else if (is_sep) begin
            if (pend_q) begin
              ev_tok_q  <= 1'b1;
              tok_val_q <= acc_q;
              tok_ovf_q <= ovf_q;
              acc_q     <= '0;
              ovf_q     <= 1'b0;
              pend_q    <= 1'b0;
            end
          end else ev_bad_q <= 1'b1;
        end
      end
      if (state_q == IDLE) begin
        if (bus.input_start) begin
          matrix_idx_q <= bus.input_idx;
          acc_q        <= '0;
          ovf_q        <= 1'b0;
          pend_q       <= 1'b0;
          cnt_q        <= '0;
          state_q      <= GET_ROW;
        end
      end else if (done_pend_q) begin
        done_pend_q <= 1'b0;
        done_q      <= 1'b1;
        state_q     <= IDLE;
      end else if (ev_bad_q || (ev_tok_q && (tok_ovf_q ||
                   (state_q != GET_ELEM && !tok_in_range)))) begin
        error_q <= 1'b1;
        state_q <= IDLE;
      end else if (ev_tok_q) begin
        case (state_q)
          GET_ROW: begin
            store_row_q <= tok_val_q[2:0];
            state_q     <= GET_COL;
          end
          GET_COL: begin
            store_col_q <= tok_val_q[2:0];
            total_q     <= store_row_q * tok_val_q[2:0];
            cnt_q       <= '0;
            state_q     <= GET_ELEM;
          end
          default: begin
            wr_en_q     <= 1'b1;
            wr_addr_q   <= cnt_q;
            wr_data_q   <= tok_val_q;
            cnt_q       <= cnt_q + 6'd1;
            done_pend_q <= (cnt_q == total_q - 6'd1);
          end
        endcase
      end
    end
  end

  assign bus.matrix_wr_en   = wr_en_q;
  assign bus.matrix_idx     = matrix_idx_q;
  assign bus.store_row      = store_row_q;
  assign bus.store_col      = store_col_q;
  assign bus.wr_addr_in     = wr_addr_q;
  assign bus.matrix_wr_data = DATA_WIDTH'(wr_data_q);
  assign bus.input_busy     = (state_q != IDLE);
  assign bus.input_done     = done_q;
  assign bus.input_error    = error_q;
endmodule

// File: tb/tb_matrix_uart_input.sv
// tb/tb_matrix_uart_input.sv - directed self-checking bench for matrix_uart_input
module tb_matrix_uart_input;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;

  matrix_uart_input_if #(.DATA_WIDTH(8)) bus ();

  matrix_uart_input #(
    .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_WIDTH(8), .MAX_SIZE(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_bv = -100;
  int done_n = 0;
  int err_n = 0;
  logic [5:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.byte_valid_q) last_bv = cyc;
      if (bus.matrix_wr_en) begin
        wr_addr_q.push_back(bus.wr_addr_in);
        wr_data_q.push_back(bus.matrix_wr_data);
        vectors++;
        if (cyc - last_bv !== 2) begin
          miscompares++;
          $display("FAIL wr_latency got %0d cycles exp 2", cyc - last_bv);
        end
      end
      if (bus.input_done) done_n++;
      if (bus.input_error) err_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(10);
    end
    uart_rx = stop_bit;
    tick(10);
    uart_rx = 1'b1;
    if (!stop_bit) tick(10);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic start_session(input logic [2:0] idx);
    bus.input_idx = idx;
    bus.input_start = 1'b1;
    tick(1);
    bus.input_start = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_n = 0;
    err_n = 0;
  endtask

  task automatic expect_session(input string name, input int n_wr, input int n_done, input int n_err);
    vectors++;
    if (wr_addr_q.size() !== n_wr) begin
      miscompares++;
      $display("FAIL %s wr_count got %0d exp %0d", name, wr_addr_q.size(), n_wr);
    end
    vectors++;
    if (done_n !== n_done) begin
      miscompares++;
      $display("FAIL %s done_count got %0d exp %0d", name, done_n, n_done);
    end
    vectors++;
    if (err_n !== n_err) begin
      miscompares++;
      $display("FAIL %s error_count got %0d exp %0d", name, err_n, n_err);
    end
    vectors++;
    if (bus.input_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after got %0b exp 0", name, bus.input_busy);
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    bus.input_start = 1'b0;
    bus.input_idx = 3'd0;
    tick(3);
    outs = {bus.matrix_wr_en, bus.matrix_idx, bus.store_row, bus.store_col, bus.wr_addr_in,
            bus.matrix_wr_data, bus.input_busy, bus.input_done, bus.input_error, 2'b00};
    vectors++;
    if (outs !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0", outs);
    end
    rst_n = 1'b1;
    tick(5);
    vectors++;
    if (bus.input_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %0b exp 0", bus.input_busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_data[4];
    exp_data = '{8'd1, 8'd2, 8'd3, 8'd4};
    clear_mon();
    start_session(3'd4);
    vectors++;
    if (bus.input_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy got %0b exp 1", bus.input_busy);
    end
    send_str("2 2 1 ");
    start_session(3'd7);
    send_str("2 3 4 ");
    tick(20);
    expect_session("basic", 4, 1, 0);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL basic_wr%0d got addr %0d data %0d exp addr %0d data %0d",
                 i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
      end
    end
    vectors++;
    if ({bus.store_row, bus.store_col, bus.matrix_idx} !== {3'd2, 3'd2, 3'd4}) begin
      miscompares++;
      $display("FAIL basic_shape got row %0d col %0d idx %0d exp 2 2 4",
               bus.store_row, bus.store_col, bus.matrix_idx);
    end
  endtask

  task automatic test_separators();
    logic [7:0] exp_data[3];
    exp_data = '{8'd7, 8'd255, 8'd0};
    clear_mon();
    start_session(3'd1);
    send_str("\r\n 3  1\n7\r\n255 0 ");
    tick(20);
    expect_session("seps", 3, 1, 0);
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL seps_wr%0d got addr %0d data %0d exp addr %0d data %0d",
                 i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
      end
    end
    vectors++;
    if ({bus.store_row, bus.store_col, bus.matrix_idx} !== {3'd3, 3'd1, 3'd1}) begin
      miscompares++;
      $display("FAIL seps_shape got row %0d col %0d idx %0d exp 3 1 1",
               bus.store_row, bus.store_col, bus.matrix_idx);
    end
  endtask

  task automatic test_bad_tokens();
    clear_mon();
    start_session(3'd2);
    send_str("6 ");
    tick(20);
    expect_session("row_range", 0, 0, 1);
    clear_mon();
    start_session(3'd2);
    send_str("2 3 300 ");
    tick(20);
    expect_session("overflow", 0, 0, 1);
  endtask

  task automatic test_bad_char();
    clear_mon();
    start_session(3'd3);
    send_str("2 2 5 a");
    tick(20);
    expect_session("bad_char", 1, 0, 1);
    vectors++;
    if (wr_addr_q.size() > 0 && (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 8'd5)) begin
      miscompares++;
      $display("FAIL bad_char_wr got addr %0d data %0d exp addr 0 data 5",
               wr_addr_q[0], wr_data_q[0]);
    end
  endtask

  task automatic test_framing();
    clear_mon();
    start_session(3'd2);
    send_str("2 ");
    send_byte(8'h33, 1'b0);
    tick(20);
    expect_session("framing", 0, 0, 1);
    clear_mon();
    start_session(3'd3);
    send_str("1 1 9 ");
    tick(20);
    expect_session("after_framing", 1, 1, 0);
    vectors++;
    if (wr_data_q.size() > 0 && wr_data_q[0] !== 8'd9) begin
      miscompares++;
      $display("FAIL after_framing_data got %0d exp 9", wr_data_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] outs;
    logic [7:0] b;
    clear_mon();
    start_session(3'd5);
    send_str("2 2 ");
    b = 8'h38;
    uart_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      tick(10);
    end
    rst_n = 1'b0;
    #1;
    outs = {bus.matrix_wr_en, bus.matrix_idx, bus.store_row, bus.store_col, bus.wr_addr_in,
            bus.matrix_wr_data, bus.input_busy, bus.input_done, bus.input_error, 2'b00};
    vectors++;
    if (outs !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got %h exp 0", outs);
    end
    tick(2);
    rst_n = 1'b1;
    for (int i = 4; i < 8; i++) begin
      uart_rx = b[i];
      tick(10);
    end
    uart_rx = 1'b1;
    tick(10);
    send_str("3 4 5 6 ");
    tick(20);
    expect_session("after_reset", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_separators();
    test_bad_tokens();
    test_bad_char();
    test_framing();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matrix_uart_input.md
MATRIX_UART_INPUT -- requirements
Module: matrix_uart_input

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, element width.
REQ-004 SHALL have parameter MAX_SIZE, default 5, max rows/cols.
REQ-005 SHALL have ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous, active-low reset
- uart_rx  input  1  8N1 serial line, idle high, asynchronous to clk
- input_start  input  1  one-cycle pulse, opens an input session
- input_idx  input  3  target matrix slot for the session
- matrix_wr_en  output  1  one-cycle write strobe per element
- matrix_idx  output  3  slot being written
- store_row  output  3  row count of session
- store_col  output  3  column count of session
- wr_addr_in  output  6  row-major element index
- matrix_wr_data  output  DATA_WIDTH  element value
- input_busy  output  1  session active
- input_done  output  1  one-cycle pulse, all elements written
- input_error  output  1  one-cycle pulse, session aborted

Function
REQ-006 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-007 Receiver SHALL detect start on synchronized falling edge, re-check low at CLKS_PER_BIT/2, sample 8 data bits LSB-first at bit centres, then sample stop bit.
REQ-008 Stop bit = 1 SHALL produce internal byte_valid for one cycle in the stop-sample cycle; stop bit = 0 SHALL produce framing_err for one cycle instead; receiver then waits for line high before re-arming.
REQ-009 Parser states SHALL be IDLE, GET_ROW, GET_COL, GET_ELEM; input_busy = 1 in all states except IDLE.
REQ-010 IDLE: input_start SHALL latch input_idx into matrix_idx, clear accumulator and element counter, go GET_ROW; bytes received in IDLE SHALL be discarded.
REQ-011 input_start while busy SHALL be ignored.
REQ-012 Tokens: ASCII '0'-'9' accumulate value = value*10 + digit; separators are 0x20, 0x0D, 0x0A; separator with no pending digits SHALL be ignored.
REQ-013 Accumulator SHALL set sticky overflow when value exceeds 255; overflow on a completed token SHALL abort.
REQ-014 GET_ROW: completed token 1..MAX_SIZE SHALL load store_row and go GET_COL; otherwise abort.
REQ-015 GET_COL: completed token 1..MAX_SIZE SHALL load store_col, clear counter, go GET_ELEM; otherwise abort.
REQ-016 GET_ELEM: each completed token SHALL drive matrix_wr_en = 1 for exactly one cycle with wr_addr_in = counter, matrix_wr_data = value, then counter increments.
REQ-017 matrix_wr_en SHALL assert exactly 2 clk cycles after byte_valid of the terminating separator.
REQ-018 Write of index store_row*store_col-1 SHALL be followed next cycle by input_done pulse and return to IDLE.
REQ-019 Any non-digit non-separator byte, or framing_err, while busy SHALL abort.
REQ-020 Abort: input_error pulse one cycle, no further writes, return IDLE; elements already written are not rolled back.
REQ-021 matrix_idx, store_row, store_col SHALL hold stable from session start until next input_start.
REQ-022 Final element requires a trailing separator; digits without separator never write.

Reset
REQ-023 rst_n low SHALL immediately force parser IDLE, receiver idle, all outputs 0, accumulator/counter/overflow cleared, synchronizer flops to 1.
REQ-024 Reset mid-session or mid-byte SHALL discard partial state; no write or pulse after release until a new input_start.

Verification (CLK_FREQ 100 MHz, BAUD_RATE 10 MHz, 10 clks/bit)
REQ-025 start idx=4, send "2 2 1 2 3 4 " -> four wr_en pulses, addr 0..3, data 1,2,3,4, store_row=2, store_col=2, matrix_idx=4, then input_done once.
REQ-026 start idx=1, send "\r\n 3  1\n7\r\n255 0 " -> writes addr 0..2 data 7,255,0, done; extra separators tolerated.
REQ-027 send "6 " -> input_error after row token, no wr_en; "2 3 300 " -> error, no wr_en.
REQ-028 send "2 2 5 a" -> one write (addr 0, data 5), then input_error on 'a', busy drops.
REQ-029 byte with stop bit 0 during GET_COL -> input_error; following valid session completes normally.
REQ-030 rst_n low mid-element byte -> all outputs 0 immediately; after release, bytes ignored until input_start.
